// File: rtl/spi_slave_fifo_if.sv
// Ready/valid FIFO-side bus of the SPI slave: TX words in, RX words out.
interface spi_slave_fifo_if #(parameter int DATA_WIDTH = 16);
  logic                  tx_valid, tx_ready, rx_valid, rx_ready;
  logic [DATA_WIDTH-1:0] tx_data, rx_data;

  modport slave  (input tx_valid, tx_data, rx_ready, output tx_ready, rx_valid, rx_data);
  modport master (output tx_valid, tx_data, rx_ready, input tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/spi_slave_fifo.sv
// SPI slave with runtime CPOL/CPHA/width, back-to-back frames per CS and
// TX/RX FIFOs; all SPI pins are synchronised into the clk domain.
module spi_slave_fifo #(
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH_LOG = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_cfg_valid,
  input  logic                          i_cfg_cpol,
  input  logic                          i_cfg_cpha,
  input  logic [$clog2(DATA_WIDTH)-1:0] i_cfg_width,
  input  logic                          i_sck,
  input  logic                          i_cs,
  input  logic                          i_mosi,
  output logic                          o_miso,
  output logic                          o_miso_oe,
  output logic                          o_tx_underrun,
  output logic                          o_rx_overflow,
  output logic                          o_busy,
  spi_slave_fifo_if.slave               fifo
);
  localparam int WW    = $clog2(DATA_WIDTH);
  localparam int FL    = FIFO_DEPTH_LOG;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_sck_s, r_cs_s, r_mosi_s;
  logic                   r_sck_d, r_cpol, r_cpha, r_push, r_underrun, r_overflow;
  logic [WW-1:0]          r_width, r_cnt;
  logic [DATA_WIDTH-1:0]  r_tx_sr, r_rx_sr, r_rx_word;
  logic [DATA_WIDTH-1:0]  r_tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  r_rx_mem [DEPTH];
  logic [FL-1:0]          r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [FL:0]            r_tx_cnt, r_rx_cnt;

  logic w_sck, w_cs, w_mosi, w_edge, w_lead, w_trail, w_sample, w_shift, w_last, w_load;
  logic w_tx_push, w_tx_pop, w_tx_empty, w_rx_push, w_rx_pop, w_rx_full;
  logic [DATA_WIDTH-1:0] w_rx_next, w_mask;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sck_s  <= '0;
      r_cs_s   <= '1;
      r_mosi_s <= '0;
      r_sck_d  <= 1'b0;
    end else begin
      r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], i_sck};
      r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], i_cs};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], i_mosi};
      r_sck_d  <= w_sck;
    end
  end

  assign w_sck   = r_sck_s[SYNC_STAGES-1];
  assign w_cs    = r_cs_s[SYNC_STAGES-1];
  assign w_mosi  = r_mosi_s[SYNC_STAGES-1];
  assign w_edge  = w_sck ^ r_sck_d;
  assign w_lead  = w_edge & (w_sck ^ r_cpol);
  assign w_trail = w_edge & ~(w_sck ^ r_cpol);

  // A shift edge seen before any sample of the current frame would skip the
  // freshly loaded MSB (cpha=1 first lead, or cpha=0 trail right after LOAD).
  assign w_sample = (r_state == SHIFT) & ~w_cs & (r_cpha ? w_trail : w_lead);
  assign w_shift  = (r_state == SHIFT) & ~w_cs & (r_cpha ? w_lead : w_trail) & (r_cnt != '0);
  assign w_last   = w_sample & (r_cnt == r_width);
  assign w_load   = (r_state == LOAD) & ~w_cs;

  assign w_rx_next = {r_rx_sr[DATA_WIDTH-2:0], w_mosi};
  assign w_mask    = ~({DATA_WIDTH{1'b1}} << (32'(r_width) + 1));

  assign fifo.tx_ready = (r_tx_cnt != (FL+1)'(DEPTH));
  assign w_tx_push     = fifo.tx_valid & fifo.tx_ready;
  assign w_tx_empty    = (r_tx_cnt == '0);
  assign w_tx_pop      = w_load & ~w_tx_empty;

  assign fifo.rx_valid = (r_rx_cnt != '0);
  assign fifo.rx_data  = r_rx_mem[r_rx_rp];
  assign w_rx_pop      = fifo.rx_ready & fifo.rx_valid;
  assign w_rx_full     = (r_rx_cnt == (FL+1)'(DEPTH));
  assign w_rx_push     = r_push & (~w_rx_full | w_rx_pop);

  always_ff @(posedge i_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= fifo.tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_word;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!w_cs) w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   if (w_last) w_next = LOAD;
      default: w_next = IDLE;
    endcase
    if (w_cs) w_next = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_width    <= WW'(DATA_WIDTH - 1);
      r_cnt      <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_word  <= '0;
      r_push     <= 1'b0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_push     <= w_last;
      r_underrun <= w_load & w_tx_empty;
      r_overflow <= r_push & w_rx_full & ~w_rx_pop;
      if (i_cfg_valid && w_cs && r_state == IDLE) begin
        r_cpol  <= i_cfg_cpol;
        r_cpha  <= i_cfg_cpha;
        r_width <= i_cfg_width;
      end
      if (w_sample) r_rx_sr <= w_rx_next;
      if (w_last)   r_rx_word <= w_rx_next & w_mask;
      if (w_load)        r_tx_sr <= w_tx_empty ? '0 : r_tx_mem[r_tx_rp];
      else if (w_shift)  r_tx_sr <= r_tx_sr << 1;
      if (w_cs || w_last || w_load) r_cnt <= '0;
      else if (w_sample)            r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_miso        = ~w_cs & r_tx_sr[r_width];
  assign o_miso_oe     = ~w_cs;
  assign o_busy        = (r_state != IDLE);
  assign o_tx_underrun = r_underrun;
  assign o_rx_overflow = r_overflow;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed bench: an SPI master model plus a queue-based scoreboard of the
// slave's TX/RX words and underrun/overflow pulse counts.
module tb_spi_slave_fifo;
  localparam int DW = 16, DEPTH = 8, HALF = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_cpol = 1'b0, cfg_cpha = 1'b0;
  logic [3:0] cfg_width = 4'd0;
  logic sck = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, tx_underrun, rx_overflow, busy;

  spi_slave_fifo_if #(.DATA_WIDTH(DW)) bus ();

  spi_slave_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH_LOG(3), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .i_cfg_cpol(cfg_cpol),
    .i_cfg_cpha(cfg_cpha), .i_cfg_width(cfg_width), .i_sck(sck), .i_cs(cs),
    .i_mosi(mosi), .o_miso(miso), .o_miso_oe(miso_oe), .o_tx_underrun(tx_underrun),
    .o_rx_overflow(rx_overflow), .o_busy(busy), .fifo(bus));

  always #5 clk = ~clk;

  int vec = 0, miss = 0;
  logic m_cpol = 1'b0, m_cpha = 1'b0;
  int m_width = 15;
  logic [15:0] tx_q[$], rx_q[$];
  logic [15:0] cur_tx = 16'h0, last_rx = 16'h0;
  int exp_und = 0, exp_ovf = 0, und_cnt = 0, ovf_cnt = 0, npop = 0;
  bit pop_pulse_pending = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vec++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endtask

  // Scoreboard: RX words must leave the FIFO in the order the master sent them.
  always @(negedge clk) begin : cmp
    logic [15:0] e;
    if (rst_n) begin
      if (tx_underrun) und_cnt++;
      if (rx_overflow) ovf_cnt++;
      chk("rx_valid_without_word", 32'(bus.rx_valid && rx_q.size() == 0), 0);
      if (bus.rx_valid && bus.rx_ready && rx_q.size() > 0) begin
        e = rx_q.pop_front();
        chk("rx_data", bus.rx_data, e);
        last_rx = bus.rx_data;
        npop++;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic half();
    cyc(HALF);
  endtask

  function automatic logic [15:0] msk(int w);
    logic [16:0] t;
    t = (17'h1 << (w + 1)) - 17'h1;
    return t[15:0];
  endfunction

  // Every frame start (CS fall or end of previous frame) consumes one TX word.
  task automatic mload();
    if (tx_q.size() > 0) cur_tx = tx_q.pop_front();
    else begin
      cur_tx = 16'h0;
      exp_und++;
    end
  endtask

  task automatic mpush(logic [15:0] w);
    if (rx_q.size() >= DEPTH && !pop_pulse_pending) exp_ovf++;
    else rx_q.push_back(w);
  endtask

  task automatic frame_done(logic [15:0] w);
    mpush(w & msk(m_width));
    if (pop_pulse_pending)
      fork
        begin
          repeat (3) @(posedge clk);
          #2 bus.rx_ready = 1'b1;
          @(posedge clk);
          #2 bus.rx_ready = 1'b0;
          pop_pulse_pending = 0;
        end
      join_none
    mload();
  endtask

  task automatic tx_write(logic [15:0] w);
    chk("tx_ready", 32'(bus.tx_ready), 32'(tx_q.size() < DEPTH));
    bus.tx_valid = 1'b1;
    bus.tx_data  = w;
    cyc(1);
    bus.tx_valid = 1'b0;
    tx_q.push_back(w);
  endtask

  task automatic cfg(logic p, logic h, int w);
    cfg_cpol = p; cfg_cpha = h; cfg_width = w[3:0]; cfg_valid = 1'b1;
    cyc(1);
    cfg_valid = 1'b0;
    if (cs) begin
      m_cpol = p; m_cpha = h; m_width = w;
    end
    cyc(2);
  endtask

  task automatic cs_fall();
    sck = m_cpol;
    cyc(4);
    cs = 1'b0;
    cyc(8);
    mload();
  endtask

  task automatic cs_rise();
    cyc(4);
    cs = 1'b1;
    cyc(8);
  endtask

  task automatic xfer(logic [15:0] wout, int nb, output logic [15:0] rin);
    logic [15:0] r;
    r = 16'h0;
    for (int i = nb - 1; i >= 0; i--) begin
      if (!m_cpha) begin
        mosi = wout[i];
        half();
        sck = ~m_cpol;
        r = {r[14:0], miso};
        if (i == 0 && nb == m_width + 1) frame_done(wout);
        half();
        sck = m_cpol;
      end else begin
        half();
        sck = ~m_cpol;
        mosi = wout[i];
        half();
        sck = m_cpol;
        r = {r[14:0], miso};
        if (i == 0 && nb == m_width + 1) frame_done(wout);
      end
    end
    half();
    rin = r;
  endtask

  task automatic frame(logic [15:0] wout, string n, output logic [15:0] got);
    logic [15:0] e;
    e = cur_tx & msk(m_width);
    xfer(wout, m_width + 1, got);
    chk(n, got, e);
  endtask

  task automatic drained(string n);
    cyc(10);
    chk(n, 32'(rx_q.size()), 0);
    chk({n, "_valid"}, 32'(bus.rx_valid), 0);
  endtask

  initial begin
    logic [15:0] got;
    int u, o, p;
    bus.tx_valid = 1'b0; bus.tx_data = 16'h0; bus.rx_ready = 1'b1;
    cyc(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_oe", 32'(miso_oe), 0);
    chk("rst_miso", 32'(miso), 0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 1);
    chk("rst_rx_valid", 32'(bus.rx_valid), 0);
    chk("rst_pulses", 32'(tx_underrun | rx_overflow), 0);
    rst_n = 1'b1;
    cyc(4);

    // 1: mode 0, 8-bit frame
    cfg(1'b0, 1'b0, 7);
    tx_write(16'h003C);
    p = npop;
    cs_fall();
    chk("t1_oe", 32'(miso_oe), 1);
    frame(16'h00A5, "t1_miso", got);
    chk("t1_miso_lit", got, 16'h003C);
    cs_rise();
    drained("t1_drained");
    chk("t1_rx_lit", last_rx, 16'h00A5);
    chk("t1_pushes", 32'(npop - p), 1);

    // 2: mode 3, 16-bit back-to-back frames; spare word covers the trailing LOAD
    cfg(1'b1, 1'b1, 15);
    tx_write(16'hCAFE); tx_write(16'h5555); tx_write(16'h8001); tx_write(16'h0000);
    u = und_cnt;
    cs_fall();
    frame(16'h1234, "t2_miso0", got);
    frame(16'hBEEF, "t2_miso1", got);
    chk("t2_miso1_lit", got, 16'h5555);
    frame(16'h0F0F, "t2_miso2", got);
    cs_rise();
    drained("t2_drained");
    chk("t2_rx_lit", last_rx, 16'h0F0F);
    chk("t2_no_underrun", 32'(und_cnt - u), 0);

    // 3: mode 1, TX empty at CS fall; refill mid-frame for the next LOAD
    cfg(1'b0, 1'b1, 7);
    u = und_cnt;
    cs_fall();
    fork begin cyc(20); tx_write(16'h0055); end join_none
    frame(16'h00C3, "t3_miso", got);
    chk("t3_miso_zero", got, 16'h0000);
    cs_rise();
    chk("t3_underrun_once", 32'(und_cnt - u), 1);
    drained("t3_drained");

    // 4: RX overflow, then a push coinciding with a pop
    cfg(1'b0, 1'b0, 7);
    bus.rx_ready = 1'b0;
    o = ovf_cnt;
    cs_fall();
    for (int i = 0; i < 9; i++) frame(16'h0010 + 16'(i), "t4_miso", got);
    cyc(4);
    chk("t4_full_valid", 32'(bus.rx_valid), 1);
    chk("t4_overflow_once", 32'(ovf_cnt - o), 1);
    pop_pulse_pending = 1;
    frame(16'h00EE, "t4_miso_last", got);
    cyc(5);
    chk("t4_no_second_overflow", 32'(ovf_cnt - o), 1);
    chk("t4_first_popped", last_rx, 16'h0010);
    cs_rise();
    bus.rx_ready = 1'b1;
    drained("t4_drained");
    chk("t4_last_lit", last_rx, 16'h00EE);

    // 5: aborted frame is discarded
    p = npop;
    cs_fall();
    xfer(16'h001F, 5, got);
    cs_rise();
    cs_fall();
    frame(16'h0081, "t5_miso", got);
    cs_rise();
    drained("t5_drained");
    chk("t5_rx_lit", last_rx, 16'h0081);
    chk("t5_pushes", 32'(npop - p), 1);

    // 6: cfg ignored while CS low, applied after; then reset mid-frame
    cs_fall();
    cfg(1'b1, 1'b0, 3);
    chk("t6_busy", 32'(busy), 1);
    frame(16'h0042, "t6_oldmode_miso", got);
    cs_rise();
    drained("t6_oldmode_drained");
    chk("t6_oldmode_rx", last_rx, 16'h0042);
    cfg(1'b1, 1'b0, 7);
    cs_fall();
    frame(16'h0099, "t6_mode2_miso", got);
    cs_rise();
    drained("t6_mode2_drained");
    chk("t6_mode2_rx", last_rx, 16'h0099);
    tx_write(16'h00FF);
    cs_fall();
    xfer(16'h00AA, 3, got);
    rst_n = 1'b0;
    cyc(1);
    chk("rst2_busy", 32'(busy), 0);
    chk("rst2_oe", 32'(miso_oe), 0);
    chk("rst2_miso", 32'(miso), 0);
    chk("rst2_tx_ready", 32'(bus.tx_ready), 1);
    chk("rst2_rx_valid", 32'(bus.rx_valid), 0);
    chk("rst2_pulses", 32'(tx_underrun | rx_overflow), 0);
    cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_q.delete(); rx_q.delete();
    m_cpol = 1'b0; m_cpha = 1'b0; m_width = 15; cur_tx = 16'h0;
    cyc(3);
    rst_n = 1'b1;
    cyc(4);
    tx_write(16'hC3A5);
    cs_fall();
    frame(16'h7E81, "t6_post_rst_miso", got);
    chk("t6_post_rst_miso_lit", got, 16'hC3A5);
    cs_rise();
    drained("t6_post_rst_drained");
    chk("t6_post_rst_rx", last_rx, 16'h7E81);

    chk("underrun_total", 32'(und_cnt), 32'(exp_und));
    chk("overflow_total", 32'(ovf_cnt), 32'(exp_ovf));
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
